// File: rtl/subv_sat_stage_if.sv
// Handshake and status bundle between the SubV subtractor, the saturating
// output stage and its downstream consumer / status reader.
interface subv_sat_stage_if #(
    parameter int width     = 8,
    parameter int cnt_width = 16
);
    // Upstream side: SubV result beat
    logic                        InValid;
    logic                        InReady;
    logic signed [width-1:0]     S;
    logic                        V;
    logic                        SatEn;

    // Downstream side: registered result beat
    logic                        OutValid;
    logic                        OutReady;
    logic signed [width-1:0]     Z;
    logic                        Sat;
    logic                        Ovf;

    // Status readout
    logic                        StickyV;
    logic                        ClrSticky;
    logic [cnt_width-1:0]        SatCnt;

    // The stage itself
    modport slave (
        input  InValid, S, V, SatEn, OutReady, ClrSticky,
        output InReady, OutValid, Z, Sat, Ovf, StickyV, SatCnt
    );

    // Whoever drives the stage (upstream, consumer and status reader together)
    modport master (
        output InValid, S, V, SatEn, OutReady, ClrSticky,
        input  InReady, OutValid, Z, Sat, Ovf, StickyV, SatCnt
    );
endinterface

// File: rtl/subv_sat_stage.sv
// Registered output stage behind the SubV subtractor.
// Each accepted beat is transformed at capture time (optional saturation of
// S to signed MAX/MIN on overflow) and stored in a 2-entry skid buffer, so
// InReady comes straight from a flop and never depends on OutReady in the
// same cycle. A sticky overflow flag and a saturating count of saturated
// beats are updated at input acceptance.
module subv_sat_stage #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic            CLK,
    input  logic            RST,
    subv_sat_stage_if.slave bus
);

    // One buffered result: the already-transformed word plus its flags.
    typedef struct packed {
        logic signed [width-1:0] z;
        logic                    sat;
        logic                    ovf;
    } entry_t;

    localparam logic [cnt_width-1:0] CNT_MAX = '1;
    localparam logic [1:0]           OCC_FULL = 2'd2;

    // Saturated value for an overflowed difference. When V is set the sign
    // bit of S is the wrong sign: a negative-looking S came from a positive
    // overflow (clamp to MAX), a positive-looking S from a negative one (MIN).
    function automatic logic signed [width-1:0] sat_word(
        input logic signed [width-1:0] s
    );
        logic signed [width-1:0] r;
        r = $signed({~s[width-1], {(width-1){s[width-1]}}});
        return r;
    endfunction

    // Build the buffer entry for one incoming beat.
    function automatic entry_t capture(
        input logic signed [width-1:0] s,
        input logic                    v,
        input logic                    sat_en
    );
        entry_t e;
        e.sat = sat_en & v;
        e.ovf = v;
        e.z   = e.sat ? sat_word(s) : s;
        return e;
    endfunction

    // Buffer state: head is what the consumer sees, tail is the skid slot.
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;
    logic                 rdy_q, rdy_d;

    // Status state
    logic                 sticky_q, sticky_d;
    logic [cnt_width-1:0] cnt_q, cnt_d;

    logic                 in_fire;
    logic                 out_fire;
    entry_t               new_ent;

    // Transfers. S/V/SatEn only matter through in_fire, so X on them while
    // InValid is low never reaches state.
    assign in_fire  = bus.InValid & rdy_q;
    assign out_fire = (occ_q != 2'd0) & bus.OutReady;
    assign new_ent  = capture(bus.S, bus.V, bus.SatEn);

    // Next-state of the skid buffer and the registered ready.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({in_fire, out_fire})
            2'b10: begin
                // Fill the first free slot; an empty buffer loads the head so
                // the beat is visible one cycle after acceptance.
                if (occ_q == 2'd0) begin
                    head_d = new_ent;
                end else begin
                    tail_d = new_ent;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                // Pop: the skid slot (possibly stale when occ was 1) moves up.
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Only reachable at occupancy 1 (in needs occ<2, out needs
                // occ>0): the new beat directly replaces the departing head.
                head_d = new_ent;
            end
            default: begin
            end
        endcase
        // Ready reflects next-cycle room, so it can be registered.
        rdy_d = (occ_d != OCC_FULL);
    end

    // Next-state of the sticky overflow flag and saturation counter; a beat
    // accepted together with ClrSticky takes priority over the clear.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (bus.ClrSticky) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (in_fire && new_ent.ovf) begin
            sticky_d = 1'b1;
        end
        if (in_fire && new_ent.sat) begin
            if (bus.ClrSticky) begin
                cnt_d = {{(cnt_width-1){1'b0}}, 1'b1};
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + {{(cnt_width-1){1'b0}}, 1'b1};
            end
        end
    end

    // Control and status registers; reset empties the buffer and holds
    // InReady low until the first edge after release.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            occ_q    <= 2'd0;
            rdy_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            occ_q    <= occ_d;
            rdy_q    <= rdy_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer data registers; cleared on reset so Z/Sat/Ovf read as zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign bus.InReady  = rdy_q;
    assign bus.OutValid = (occ_q != 2'd0);
    assign bus.Z        = head_q.z;
    assign bus.Sat      = head_q.sat;
    assign bus.Ovf      = head_q.ovf;
    assign bus.StickyV  = sticky_q;
    assign bus.SatCnt   = cnt_q;

endmodule

// File: tb/tb_subv_sat_stage.sv
// Directed bench for subv_sat_stage (width=8, cnt_width=2 so counter
// saturation is reachable in a few beats).
module tb_subv_sat_stage;

    logic CLK;
    logic RST;
    int   pass_cnt;
    int   chk_cnt;

    subv_sat_stage_if #(.width(8), .cnt_width(2)) bus ();

    subv_sat_stage #(.width(8), .cnt_width(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] s, input logic v, input logic se);
        bus.InValid = iv;
        bus.S       = s;
        bus.V       = v;
        bus.SatEn   = se;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        bus.OutReady  = 1'b0;
        bus.ClrSticky = 1'b0;
        step();
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.InReady} !== 2'b00) $display("FAIL reset_handshake got %b expected 00", {bus.OutValid, bus.InReady});
        else pass_cnt++;
        chk_cnt++;
        if ({bus.Z, bus.Sat, bus.Ovf, bus.StickyV, bus.SatCnt} !== 13'h0) $display("FAIL reset_values Z=%h Sat=%b Ovf=%b StickyV=%b SatCnt=%0d expected all 0", bus.Z, bus.Sat, bus.Ovf, bus.StickyV, bus.SatCnt);
        else pass_cnt++;
        RST = 1'b0;
        #1;
        chk_cnt++;
        if (bus.InReady !== 1'b0) $display("FAIL ready_before_edge got %b expected 0", bus.InReady);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.InReady !== 1'b1) $display("FAIL ready_after_release got %b expected 1", bus.InReady);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        bus.OutReady = 1'b1;
        // Positive overflow -> MAX
        drive(1'b1, 8'h80, 1'b1, 1'b1);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.StickyV, bus.SatCnt} !== {1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 2'd1})
            $display("FAIL sat_max valid=%b Z=%h Sat=%b Ovf=%b StickyV=%b SatCnt=%0d expected 1 7f 1 1 1 1", bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.StickyV, bus.SatCnt);
        else pass_cnt++;
        // Negative overflow -> MIN, back to back
        drive(1'b1, 8'h7F, 1'b1, 1'b1);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.SatCnt} !== {1'b1, 8'h80, 1'b1, 1'b1, 2'd2})
            $display("FAIL sat_min valid=%b Z=%h Sat=%b Ovf=%b SatCnt=%0d expected 1 80 1 1 2", bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.SatCnt);
        else pass_cnt++;
        // Same inputs with saturation disabled -> pass through
        drive(1'b1, 8'h7F, 1'b1, 1'b0);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.SatCnt} !== {1'b1, 8'h7F, 1'b0, 1'b1, 2'd2})
            $display("FAIL sat_disabled valid=%b Z=%h Sat=%b Ovf=%b SatCnt=%0d expected 1 7f 0 1 2", bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.SatCnt);
        else pass_cnt++;
        // SatEn without V -> pass through, no flags
        drive(1'b1, 8'h80, 1'b0, 1'b1);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.SatCnt} !== {1'b1, 8'h80, 1'b0, 1'b0, 2'd2})
            $display("FAIL no_overflow valid=%b Z=%h Sat=%b Ovf=%b SatCnt=%0d expected 1 80 0 0 2", bus.OutValid, bus.Z, bus.Sat, bus.Ovf, bus.SatCnt);
        else pass_cnt++;
        // X on data while idle must not matter
        drive(1'b0, 8'hxx, 1'bx, 1'bx);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.SatCnt, bus.StickyV} !== {1'b0, 2'd2, 1'b1})
            $display("FAIL idle_drain valid=%b SatCnt=%0d StickyV=%b expected 0 2 1", bus.OutValid, bus.SatCnt, bus.StickyV);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus.OutReady = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z} !== {1'b1, 1'b1, 8'h01}) $display("FAIL bp_first valid=%b ready=%b Z=%h expected 1 1 01", bus.OutValid, bus.InReady, bus.Z);
        else pass_cnt++;
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z} !== {1'b1, 1'b0, 8'h01}) $display("FAIL bp_full valid=%b ready=%b Z=%h expected 1 0 01", bus.OutValid, bus.InReady, bus.Z);
        else pass_cnt++;
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z} !== {1'b1, 1'b0, 8'h01}) $display("FAIL bp_hold valid=%b ready=%b Z=%h expected 1 0 01", bus.OutValid, bus.InReady, bus.Z);
        else pass_cnt++;
        // Release: 0x01 leaves, 0x03 is still waiting upstream
        bus.OutReady = 1'b1;
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z} !== {1'b1, 1'b1, 8'h02}) $display("FAIL bp_drain1 valid=%b ready=%b Z=%h expected 1 1 02", bus.OutValid, bus.InReady, bus.Z);
        else pass_cnt++;
        // 0x02 leaves while 0x03 enters
        step();
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z} !== {1'b1, 1'b1, 8'h03}) $display("FAIL bp_drain2 valid=%b ready=%b Z=%h expected 1 1 03", bus.OutValid, bus.InReady, bus.Z);
        else pass_cnt++;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if (bus.OutValid !== 1'b0) $display("FAIL bp_empty valid=%b expected 0", bus.OutValid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        bus.OutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = 8'h10 + 8'(i);
            drive(1'b1, exp, 1'b0, 1'b1);
            step();
            chk_cnt++;
            if ({bus.OutValid, bus.InReady, bus.Z} !== {1'b1, 1'b1, exp})
                $display("FAIL stream_beat%0d valid=%b ready=%b Z=%h expected 1 1 %h", i, bus.OutValid, bus.InReady, bus.Z, exp);
            else pass_cnt++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk_cnt++;
        if (bus.OutValid !== 1'b0) $display("FAIL stream_end valid=%b expected 0", bus.OutValid);
        else pass_cnt++;
    endtask

    task automatic test_counter();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus.OutReady  = 1'b1;
        bus.ClrSticky = 1'b1;
        step();
        bus.ClrSticky = 1'b0;
        chk_cnt++;
        if ({bus.SatCnt, bus.StickyV} !== {2'd0, 1'b0}) $display("FAIL clr_initial SatCnt=%0d StickyV=%b expected 0 0", bus.SatCnt, bus.StickyV);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h80, 1'b1, 1'b1);
            step();
            chk_cnt++;
            if (bus.SatCnt !== exp_cnt[i]) $display("FAIL satcnt_%0d got %0d expected %0d", i, bus.SatCnt, exp_cnt[i]);
            else pass_cnt++;
        end
        // Clear with a simultaneous saturated beat: the beat wins
        bus.ClrSticky = 1'b1;
        step();
        chk_cnt++;
        if ({bus.SatCnt, bus.StickyV} !== {2'd1, 1'b1}) $display("FAIL clr_with_beat SatCnt=%0d StickyV=%b expected 1 1", bus.SatCnt, bus.StickyV);
        else pass_cnt++;
        // Clear alone
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        bus.ClrSticky = 1'b0;
        chk_cnt++;
        if ({bus.SatCnt, bus.StickyV} !== {2'd0, 1'b0}) $display("FAIL clr_alone SatCnt=%0d StickyV=%b expected 0 0", bus.SatCnt, bus.StickyV);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus.OutReady = 1'b0;
        drive(1'b1, 8'h80, 1'b1, 1'b1);
        step();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z, bus.StickyV} !== {1'b1, 1'b0, 8'h7F, 1'b1})
            $display("FAIL pre_reset_full valid=%b ready=%b Z=%h StickyV=%b expected 1 0 7f 1", bus.OutValid, bus.InReady, bus.Z, bus.StickyV);
        else pass_cnt++;
        // Assert mid-cycle, check before any clock edge
        #2;
        RST = 1'b1;
        #1;
        chk_cnt++;
        if ({bus.OutValid, bus.InReady, bus.Z, bus.StickyV, bus.SatCnt} !== {1'b0, 1'b0, 8'h00, 1'b0, 2'd0})
            $display("FAIL async_reset valid=%b ready=%b Z=%h StickyV=%b SatCnt=%0d expected 0 0 00 0 0", bus.OutValid, bus.InReady, bus.Z, bus.StickyV, bus.SatCnt);
        else pass_cnt++;
        step();
        RST = 1'b0;
        bus.OutReady = 1'b1;
        #1;
        chk_cnt++;
        if (bus.InReady !== 1'b0) $display("FAIL async_ready_early got %b expected 0", bus.InReady);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({bus.InReady, bus.OutValid} !== 2'b10) $display("FAIL async_release ready=%b valid=%b expected 1 0", bus.InReady, bus.OutValid);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (bus.OutValid !== 1'b0) $display("FAIL stale_beat valid=%b Z=%h expected valid 0", bus.OutValid, bus.Z);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        test_reset();
        test_saturate();
        test_backpressure();
        test_back_to_back();
        test_counter();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
